// File: rtl/la_capture.sv
// la_capture: trigger-qualified capture of a probe bus into a circular buffer,
// followed by oldest-first readout of the DEPTH-sample window.
module la_capture #(
   parameter int AW = 8,
   parameter int W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  probe,
   input  logic          arm,
   input  logic [W-1:0]  trig_mask,
   input  logic [W-1:0]  trig_value,
   input  logic [AW-1:0] pre_count,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          rd_valid,
   output logic [1:0]    state_o,
   output logic          triggered,
   output logic          done
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
   state_t r_state, w_next;
   logic [W-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_rd_cnt, r_remaining, r_pre;
   logic [AW:0] r_cnt;
   logic [W-1:0] r_mask, r_value, r_rd_data;
   logic r_triggered, r_rd_valid;
   logic w_arm, w_trig, w_wr, w_rd;
   always_comb begin
      w_arm  = arm && (r_state == IDLE || r_state == DONE);
      w_trig = r_state == ARMED && ((probe ^ r_value) & r_mask) == '0 && r_cnt >= {1'b0, r_pre};
      w_wr   = r_state == ARMED || r_state == POST;
      w_rd   = r_state == DONE && rd_en && !arm;
      w_next = w_arm ? ARMED :
               w_trig ? ((&r_pre) ? DONE : POST) :
               (r_state == POST && r_remaining == AW'(1)) ? DONE :
               (w_rd && (&r_rd_cnt)) ? IDLE : r_state;
   end
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr] <= probe;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_rd_cnt    <= '0;
         r_cnt       <= '0;
         r_remaining <= '0;
         r_pre       <= '0;
         r_mask      <= '0;
         r_value     <= '0;
         r_triggered <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_state    <= w_next;
         r_rd_valid <= w_rd;
         if (w_arm) begin
            r_mask      <= trig_mask;
            r_value     <= trig_value;
            r_pre       <= pre_count;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
         end
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
         end
         // Readout starts at the oldest retained sample, known as soon as the trigger lands
         if (w_trig) begin
            r_triggered <= 1'b1;
            r_remaining <= ~r_pre;
            r_rd_ptr    <= r_wr_ptr - r_pre;
         end else if (r_state == POST) r_remaining <= r_remaining - 1'b1;
         if (w_rd) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_cnt  <= r_rd_cnt + 1'b1;
         end
      end
   end
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign state_o   = r_state;
   assign triggered = r_triggered;
   assign done      = (r_state == DONE);
endmodule

// File: tb/tb_la_capture.sv
// tb_la_capture: randomized capture scenarios; a window model feeds a readout scoreboard.
module tb_la_capture;
   logic clk = 1'b0;
   logic rst, arm, rd_en;
   logic [15:0] probe, trig_mask, trig_value;
   logic [7:0] pre_count;
   logic [15:0] rd_data;
   logic rd_valid, triggered, done;
   logic [1:0] state_o;
   int n_vec = 0, n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w, last_rd;
   logic [15:0] seq [2048];
   always #5 clk = ~clk;
   la_capture #(.AW(8), .W(16)) dut (
      .clk(clk), .rst(rst), .probe(probe), .arm(arm), .trig_mask(trig_mask),
      .trig_value(trig_value), .pre_count(pre_count), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .state_o(state_o), .triggered(triggered), .done(done)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rd_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got %h expected no read", rd_data);
         end else begin
            exp_w = exp_q.pop_front();
            if (rd_data !== exp_w) begin
               n_err++;
               $display("FAIL rd_data: got %h expected %h", rd_data, exp_w);
            end
         end
      end
   end
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
   endtask
   task automatic fill_random(input logic [15:0] avoid, input bit use_avoid);
      for (int i = 0; i < 2048; i++) begin
         seq[i] = 16'($urandom);
         if (use_avoid && seq[i] == avoid) seq[i] = ~avoid;
      end
   endtask
   // Sample k is the k-th write after arm; trigger is the first matching k with k >= pre.
   task automatic capture(input logic [15:0] m, input logic [15:0] v, input logic [7:0] p,
                          input bit hold_rd, output int t);
      int k;
      bit saw_post;
      t = -1;
      for (int i = 0; i < 2048; i++)
         if (t < 0 && ((seq[i] ^ v) & m) == 16'h0 && i >= int'(p)) t = i;
      trig_mask = m; trig_value = v; pre_count = p; rd_en = hold_rd; arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      chk("armed", state_o, 1);
      chk("trig_cleared", triggered, 0);
      k = 0;
      saw_post = 1'b0;
      while (!done && k < 1500) begin
         if (k == t) begin
            chk("armed_at_trig", state_o, 1);
            chk("not_done_at_trig", done, 0);
         end
         probe = seq[k];
         @(posedge clk); #1;
         k++;
         if (state_o == 2'd2) saw_post = 1'b1;
         if (hold_rd) chk("rd_valid_armed", rd_valid, 0);
      end
      rd_en = 1'b0;
      chk("writes", k, t + 256 - int'(p));
      chk("triggered", triggered, 1);
      chk("post_visited", saw_post, p != 8'hFF);
   endtask
   task automatic readout(input int t, input int p);
      int n, b;
      for (int i = 0; i < 256; i++) exp_q.push_back(seq[t - p + i]);
      n = 0;
      b = 0;
      while (n < 256 && b < 2000) begin
         rd_en = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         if (rd_en) n++;
         #1;
         b++;
      end
      rd_en = 1'b0;
      chk("idle_after_read", state_o, 0);
      last_rd = seq[t - p + 255];
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
   endtask
   initial begin
      int t;
      logic [7:0] p;
      rst = 1'b1; arm = 1'b0; rd_en = 1'b0; probe = '0;
      trig_mask = '0; trig_value = '0; pre_count = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state_o, 0);
      chk("rst_triggered", triggered, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;
      // incrementing probe, exact-value trigger with 4 samples of history
      for (int i = 0; i < 2048; i++) seq[i] = 16'(i);
      capture(16'hFFFF, 16'h0010, 8'd4, 1'b1, t);
      chk("trig_sample", seq[t], 16'h0010);
      readout(t, 4);
      chk("last_read", last_rd, 16'h010B);
      rd_en = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rd_valid_idle", rd_valid, 0);
         chk("rd_data_hold", rd_data, last_rd);
      end
      rd_en = 1'b0;
      // mask 0: fire immediately
      fill_random(16'h0, 1'b0);
      capture(16'h0000, 16'(($urandom)), 8'd0, 1'b0, t);
      readout(t, 0);
      // maximum history: trigger deferred to the 256th sample, no POST phase
      for (int i = 0; i < 2048; i++) seq[i] = 16'h5A5A;
      capture(16'hFFFF, 16'h5A5A, 8'd255, 1'b0, t);
      readout(t, 255);
      chk("last_is_trig", last_rd, seq[t]);
      repeat (4) begin
         fill_random(16'h0, 1'b0);
         p = 8'($urandom_range(0, 255));
         capture(16'h0007, 16'($urandom_range(0, 7)), p, 1'($urandom_range(0, 1)), t);
         readout(t, int'(p));
      end
      // long search: pointer wraps and cnt saturates before a late trigger
      fill_random(16'hBEEF, 1'b1);
      seq[1000] = 16'hBEEF;
      capture(16'hFFFF, 16'hBEEF, 8'd200, 1'b0, t);
      readout(t, 200);
      // reset during POST abandons the capture
      trig_mask = '0; trig_value = '0; pre_count = 8'd10; arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      repeat (20) begin
         probe = 16'($urandom);
         @(posedge clk); #1;
      end
      chk("in_post", state_o, 2);
      chk("post_triggered", triggered, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_state", state_o, 0);
      chk("midrst_triggered", triggered, 0);
      chk("midrst_done", done, 0);
      fill_random(16'h0, 1'b0);
      p = 8'($urandom_range(0, 255));
      capture(16'h0003, 16'($urandom_range(0, 3)), p, 1'b0, t);
      readout(t, int'(p));
      // arm together with rd_en in DONE restarts without reading
      fill_random(16'h0, 1'b0);
      capture(16'h0000, 16'h0000, 8'd0, 1'b0, t);
      for (int i = 0; i < 5; i++) exp_q.push_back(seq[i]);
      rd_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      rd_en = 1'b0;
      chk("abort_state", state_o, 1);
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_triggered", triggered, 0);
      chk("abort_queue", exp_q.size(), 0);
      do_reset();
      chk("final_state", state_o, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
